vend_controller: RTL

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// Drink vending controller: half-yuan credit, one-cycle registered outputs, handshake-held dispense/change requests.
// Defining VEND_TIMEOUT_REFUND_EN adds an inactivity counter that refunds credit after TIMEOUT_CYCLES idle cycles.
module vend_controller #(
    parameter int PRICE_HALVES      = 3,
    parameter int MAX_CREDIT_HALVES = 6,
    parameter int TIMEOUT_CYCLES    = 10
) (
    input  logic        clk_1Hz,
    input  logic        reset,
    input  logic        coin1,
    input  logic        coin0_5,
    input  logic        cancel,
    input  logic        disp_ack,
    input  logic        chg_ack,
    output logic        disp_req,
    output logic        chg_req,
    output logic        coin_reject,
    output logic        busy,
    output logic [15:0] credit_bcd
);
    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    localparam logic [4:0] PRICE_W = 5'(PRICE_HALVES);
    localparam logic [4:0] MAX_W   = 5'(MAX_CREDIT_HALVES);

    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       disp_req_q, chg_req_q, coin_reject_q, busy_q;
    logic       coin_ok, reject_d, timeout;
    logic [4:0] coin_val, credit_ext, credit_sum;

    // coin1 wins a simultaneous pair; the 0.5 coin is always bounced in that case
    assign coin_val   = coin1 ? 5'd2 : (coin0_5 ? 5'd1 : 5'd0);
    assign credit_ext = {1'b0, credit_q};
    assign credit_sum = credit_ext + coin_val;
    assign coin_ok    = ((state_q == IDLE) || (state_q == CREDIT)) &&
                        (coin_val != 5'd0) && (credit_sum <= MAX_W);
    assign reject_d   = (coin1 && coin0_5) || ((coin1 || coin0_5) && !coin_ok);

`ifdef VEND_TIMEOUT_REFUND_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign timeout = (state_q == CREDIT) && !coin_ok && (tmo_q == TMO_LAST);
    assign tmo_d   = ((state_q == CREDIT) && !coin_ok && (state_d == CREDIT))
                     ? tmo_q + TW'(1) : '0;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            IDLE, CREDIT: begin
                if (coin_ok) credit_d = credit_sum[3:0];
                // Enough registered credit always vends first; cancel/timeout lose that race
                if (credit_ext >= PRICE_W)
                    state_d = DISPENSE;
                else if ((state_q == CREDIT) && (cancel || timeout))
                    state_d = CHANGE;
                else
                    state_d = (credit_d == 4'd0) ? IDLE : CREDIT;
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_d = credit_q - PRICE_W[3:0];
                    state_d  = (credit_d == 4'd0) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                if (credit_q == 4'd0) begin
                    state_d = IDLE;
                end else if (chg_ack) begin
                    credit_d = credit_q - 4'd1;
                    if (credit_d == 4'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= 4'd0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef VEND_TIMEOUT_REFUND_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= (state_d == DISPENSE);
            chg_req_q     <= (state_d == CHANGE);
            coin_reject_q <= reject_d;
            busy_q        <= (state_d == DISPENSE) || (state_d == CHANGE);
`ifdef VEND_TIMEOUT_REFUND_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign disp_req    = disp_req_q;
    assign chg_req     = chg_req_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;
    assign credit_bcd  = {8'h00, 1'b0, credit_q[3:1], (credit_q[0] ? 4'h5 : 4'h0)};
endmodule
